// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
// The block itself is the slave; the pixel source and window consumer form the master side.
interface conv_window_gen_if #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K_H        = 3,
  parameter int K_W        = 3,
  parameter int DATA_WIDTH = 9
);
  logic                                in_valid;
  logic                                in_ready;
  logic signed [DATA_WIDTH-1:0]        in_pixel;
  logic                                win_valid;
  logic                                win_ready;
  logic [K_H*K_W*DATA_WIDTH-1:0]       conv_win;
  logic [$clog2(IMG_H)-1:0]            win_row;
  logic [$clog2(IMG_W)-1:0]            win_col;

  modport slave (
    input  in_valid, in_pixel, win_ready,
    output in_ready, win_valid, conv_win, win_row, win_col
  );

  modport master (
    output in_valid, in_pixel, win_ready,
    input  in_ready, win_valid, conv_win, win_row, win_col
  );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding K_H x K_W window generator: line buffers plus a window register, fed by a
// row-major pixel stream, with backpressure so a stalled consumer never loses a window.
module conv_window_gen #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K_H        = 3,
  parameter int K_W        = 3,
  parameter int DATA_WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  conv_window_gen_if.slave bus,
  output logic             busy,
  output logic             frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LB = K_H - 1;
  localparam int WB = K_H * K_W * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [WB-1:0]   win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic [RW-1:0]   win_row_q, win_row_d;
  logic [CW-1:0]   win_col_q, win_col_d;
  logic            accept;
  logic            in_ready;

  // line_mem[0] holds the oldest buffered row, line_mem[LB-1] the row just above the current one
  logic signed [DATA_WIDTH-1:0] line_mem [LB][IMG_W];
  logic signed [DATA_WIDTH-1:0] col_new  [K_H];

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    frame_done  = 1'b0;

    in_ready = (state_q == STREAM) && !(win_valid_q && !bus.win_ready);
    accept   = bus.in_valid && in_ready;

    for (int r = 0; r < LB; r++) col_new[r] = line_mem[r][col_q];
    col_new[K_H-1] = bus.in_pixel;

    if (win_valid_q && bus.win_ready) win_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          col_d   = '0;
          row_d   = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W - 1; c++)
              win_d[(r*K_W+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[(r*K_W+c+1)*DATA_WIDTH +: DATA_WIDTH];
            win_d[(r*K_W+K_W-1)*DATA_WIDTH +: DATA_WIDTH] = col_new[r];
          end
          // A newly completed window overrides the clear from a same-cycle consume
          if (col_q >= CW'(K_W-1) && row_q >= RW'(K_H-1)) begin
            win_valid_d = 1'b1;
            win_row_d   = row_q - RW'(K_H-1);
            win_col_d   = col_q - CW'(K_W-1);
          end
          if (col_q == CW'(IMG_W-1)) begin
            col_d = '0;
            if (row_q == RW'(IMG_H-1)) state_d = DRAIN;
            else                       row_d   = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (win_valid_q && bus.win_ready) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  // Each buffered row moves up one slot at the current column; the new pixel enters the bottom
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < LB - 1; r++) line_mem[r][col_q] <= line_mem[r+1][col_q];
      line_mem[LB-1][col_q] <= bus.in_pixel;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.conv_win  = win_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x4 image with a 3x3 window.
module tb_conv_window_gen;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int K_H   = 3;
  localparam int K_W   = 3;
  localparam int DW    = 9;
  localparam int WB    = K_H * K_W * DW;
  localparam int NWIN  = (IMG_H - K_H + 1) * (IMG_W - K_W + 1);
  localparam int NPIX  = IMG_W * IMG_H;

  typedef struct {
    int orow;
    int ocol;
    int tl;
  } win_rec_t;

  typedef struct {
    int          row;
    int          col;
    logic [WB-1:0] data;
  } got_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic frame_done;

  conv_window_gen_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K_H(K_H), .K_W(K_W), .DATA_WIDTH(DW)) bus ();

  conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K_H(K_H), .K_W(K_W), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  win_rec_t tbl [NWIN];
  got_t     got_q [$];
  int       fd_cnt    = 0;
  int       acc_cnt   = 0;
  int       first_acc = -1;
  logic     wv_prev   = 1'b0;
  int       n_chk     = 0;
  int       n_fail    = 0;

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observer: records consumed windows, frame_done pulses and pixel accepts
  initial begin : mon
    forever begin
      @(negedge clk);
      if (bus.win_valid && !wv_prev && first_acc < 0) first_acc = acc_cnt;
      wv_prev = bus.win_valid;
      if (bus.win_valid && bus.win_ready)
        got_q.push_back('{int'(bus.win_row), int'(bus.win_col), bus.conv_win});
      if (frame_done) fd_cnt++;
      if (bus.in_valid && bus.in_ready) acc_cnt++;
    end
  end

  function automatic logic [DW-1:0] pix(input int mode, input int idx);
    if (mode == 1) return 9'h100;
    if (mode == 2) return DW'(idx + 100);
    return DW'(idx);
  endfunction

  task automatic clear_mon();
    got_q.delete();
    fd_cnt    = 0;
    acc_cnt   = 0;
    first_acc = -1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int mode, input int gap_pct, input int npx, input int start_at);
    int   idx = 0;
    int   cyc = 0;
    logic fire;
    while (idx < npx && cyc < 1000) begin
      bus.in_valid = (int'($urandom_range(99)) >= gap_pct);
      bus.in_pixel = pix(mode, idx);
      start        = (idx == start_at);
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    chk_i("stream_accepts", idx, npx);
  endtask

  task automatic wait_done();
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = frame_done;
      n++;
    end
    @(posedge clk); #1;
    chk_i("frame_done_seen", int'(seen), 1);
  endtask

  task automatic check_frame(input string tag, input int mode);
    logic [WB-1:0] e;
    int            n;
    chk_i($sformatf("%s_nwin", tag), got_q.size(), NWIN);
    chk_i($sformatf("%s_frame_done_cnt", tag), fd_cnt, 1);
    chk_i($sformatf("%s_busy_after", tag), int'(busy), 0);
    n = (got_q.size() < NWIN) ? got_q.size() : NWIN;
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < K_H; r++)
        for (int c = 0; c < K_W; c++)
          e[(r*K_W+c)*DW +: DW] = (mode == 1) ? 9'h100 :
                                  DW'(tbl[i].tl + IMG_W*r + c + ((mode == 2) ? 100 : 0));
      chk_i($sformatf("%s_w%0d_row", tag, i), got_q[i].row, tbl[i].orow);
      chk_i($sformatf("%s_w%0d_col", tag, i), got_q[i].col, tbl[i].ocol);
      chk_w($sformatf("%s_w%0d_data", tag, i), got_q[i].data, e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_i($sformatf("%s_in_ready", tag), int'(bus.in_ready), 0);
    chk_i($sformatf("%s_win_valid", tag), int'(bus.win_valid), 0);
    chk_i($sformatf("%s_busy", tag), int'(busy), 0);
    chk_i($sformatf("%s_frame_done", tag), int'(frame_done), 0);
    chk_w($sformatf("%s_conv_win", tag), bus.conv_win, '0);
    chk_i($sformatf("%s_win_row", tag), int'(bus.win_row), 0);
    chk_i($sformatf("%s_win_col", tag), int'(bus.win_col), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [WB-1:0] held;
    int            n;

    // Expected windows in raster order: output position and top-left pixel value
    tbl = '{'{0, 0, 0}, '{0, 1, 1}, '{0, 2, 2}, '{1, 0, 5}, '{1, 1, 6}, '{1, 2, 7}};

    rst           = 1'b1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.win_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic stream
    clear_mon();
    do_start();
    chk_i("start_in_ready", int'(bus.in_ready), 1);
    chk_i("start_busy", int'(busy), 1);
    stream(0, 0, NPIX, -1);
    wait_done();
    check_frame("basic", 0);
    chk_i("first_win_after_accepts", first_acc, (K_H-1)*IMG_W + K_W);

    // Backpressure: consumer stalls until the first window has been held 4 cycles
    clear_mon();
    bus.win_ready = 1'b0;
    do_start();
    fork
      stream(0, 0, NPIX, -1);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.win_valid && n < 100);
        chk_i("bp_win_seen", int'(bus.win_valid), 1);
        held = bus.conv_win;
        for (int i = 0; i < 4; i++) begin
          chk_i($sformatf("bp_in_ready_c%0d", i), int'(bus.in_ready), 0);
          chk_i($sformatf("bp_win_valid_c%0d", i), int'(bus.win_valid), 1);
          chk_w($sformatf("bp_hold_c%0d", i), bus.conv_win, held);
          if (i < 3) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.win_ready = 1'b1;
      end
    join
    wait_done();
    check_frame("bp", 0);

    // Random 50% gaps on in_valid
    clear_mon();
    do_start();
    stream(0, 50, NPIX, -1);
    wait_done();
    check_frame("gap", 0);

    // All pixels at the most negative value
    clear_mon();
    do_start();
    stream(1, 0, NPIX, -1);
    wait_done();
    check_frame("signed", 1);

    // Reset after 8 accepts, then a fresh frame with different data
    clear_mon();
    do_start();
    stream(1, 0, 8, -1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_i("midrst_idle_in_ready", int'(bus.in_ready), 0);
    chk_i("midrst_no_frame_done", fd_cnt, 0);
    @(posedge clk); #1;
    clear_mon();
    do_start();
    stream(2, 0, NPIX, -1);
    wait_done();
    check_frame("after_rst", 2);

    // Start pulsed mid-frame is ignored; second frame starts right after frame_done
    clear_mon();
    do_start();
    stream(0, 0, NPIX, 7);
    wait_done();
    check_frame("midstart", 0);
    clear_mon();
    do_start();
    chk_i("b2b_in_ready", int'(bus.in_ready), 1);
    stream(0, 0, NPIX, -1);
    wait_done();
    check_frame("b2b", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streams a feature map in row-major order, one signed pixel per handshake, and presents every valid K_H×K_W sliding window (stride 1, no padding) to the downstream convolution unit. The downstream unit consumes `conv_win` combinationally. Internally the block holds K_H-1 line buffers and a K_H×K_W window register. It applies valid/ready backpressure so that no window is dropped when the consumer stalls.

## Interface
- `IMG_W`, 28, input feature-map width in pixels (≥ K_W)
- `IMG_H`, 28, input feature-map height in pixels (≥ K_H)
- `K_H`, 3, window height
- `K_W`, 3, window width
- `DATA_WIDTH`, 9, signed pixel width

Reset is asynchronous and active-high.

- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse that begins a frame; honoured only in IDLE
- `in_valid` in 1: `in_pixel` is valid
- `in_ready` out 1: block accepts a pixel this cycle
- `in_pixel` in DATA_WIDTH: signed pixel, row-major
- `win_valid` out 1: `conv_win` holds a complete window
- `win_ready` in 1: consumer takes the window this cycle
- `conv_win` out K_H*K_W*DATA_WIDTH: element (r,c) at bits [(r*K_W+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top (oldest) row, c=0 is the leftmost column
- `win_row` out $clog2(IMG_H): output row index of the current window
- `win_col` out $clog2(IMG_W): output column index of the current window
- `busy` out 1: high in STREAM and DRAIN
- `frame_done` out 1: one-cycle pulse when the last window has been consumed

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - `in_ready`=0.
  - `start` → STREAM, clearing the pixel counters (`col_cnt`, `row_cnt`).
- STREAM:
  - Pixel accept = `in_valid && in_ready`.
  - `in_ready` = !(`win_valid && !win_ready`): accept only if the output slot is free or is being emptied this cycle.
  - On each accept:
    - the line buffers shift;
    - the window register shifts one column left;
    - the new right column is {line-buffer taps at `col_cnt` (oldest row first), `in_pixel`}.
  - `col_cnt` wraps from IMG_W-1 to 0 and increments `row_cnt`.
  - The window is complete when the accepted pixel has `col_cnt` ≥ K_W-1 and `row_cnt` ≥ K_H-1.
  - On a complete window, the registered outputs update: `win_valid`=1, `win_row`=`row_cnt`-(K_H-1), `win_col`=`col_cnt`-(K_W-1).
  - Accepting pixel (IMG_H-1, IMG_W-1) → DRAIN.
- DRAIN:
  - `in_ready`=0.
  - When `win_valid && win_ready` → IDLE, with `frame_done` pulsed that same cycle.
- Window content: the window at (orow, ocol) holds input pixels (orow+r, ocol+c) for all r, c. Values pass through unmodified; the sign is preserved and there is no arithmetic.
- `win_valid` clears on `win_ready` unless a new complete window is produced in the same cycle.
- Windows per frame = (IMG_H-K_H+1)*(IMG_W-K_W+1). Horizontally partial windows at row starts are never flagged valid.
- `start` outside IDLE is ignored.
- `in_valid` may drop at any time; state holds across gaps.

## Timing
- Reset values:
  - state=IDLE;
  - `in_ready`=0, `win_valid`=0, `busy`=0, `frame_done`=0;
  - `conv_win`=0, `win_row`=0, `win_col`=0;
  - counters=0.
  - Line-buffer contents are don't-care.
- `rst` asserted mid-frame aborts immediately. No `frame_done` is produced, and the next frame requires a new `start`.
- Latency: `win_valid` rises the cycle after the accept of its bottom-right pixel.
- Throughput: 1 window/cycle with `in_valid` and `win_ready` held high.
- First window: follows accept number (K_H-1)*IMG_W+K_W.
- `start` → first `in_ready`=1: 1 cycle.
- `frame_done` → next `start` is accepted on the following cycle.
- Simultaneous `win_ready` and a new window completing: the new window replaces the old one, and `win_valid` stays 1.

## Test plan
- Basic stream, IMG_W=5, IMG_H=4, K=3×3, pixel value = 5*row+col, `in_valid`=`win_ready`=1:
  - exactly 6 windows, raster order;
  - first window {0,1,2,5,6,7,10,11,12} at (0,0), one cycle after pixel 12 is accepted;
  - last window {7,8,9,12,13,14,17,18,19} at (1,2);
  - `frame_done` is one pulse.
- Backpressure: `win_ready`=0 for 4 cycles after the first window → `in_ready`=0 and the window is held stable; on release, all 6 windows arrive with none lost or duplicated.
- Random gaps on `in_valid` (50%) → the same 6 windows, in the same order, as the basic stream.
- Signed data: all pixels = -256 (9'h100) → every `conv_win` element = 9'h100.
- `rst` after 8 accepts, then `start` with a fresh frame → outputs return to reset values and the windows are correct, with no stale data.
- Second `start` pulsed mid-frame → ignored; a back-to-back second frame following `frame_done` yields 6 correct windows.
